// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icodes, status codes, register id and sequencer state type
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - combinational hazard detection and RUN-state pipeline register controls
module hazard_unit
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] E_icode,
    input  logic [3:0] M_icode,
    input  logic [3:0] E_dstM,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic       e_Cnd,
    output logic       load_use,
    output logic       ret_pend,
    output logic       mispred,
    output logic       run_F_stall,
    output logic       run_D_stall,
    output logic       run_D_bubble,
    output logic       run_E_bubble
);

    logic w_e_is_load;

    assign w_e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
    assign load_use    = w_e_is_load && (E_dstM != RNONE) &&
                         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_pend    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred     = (E_icode == I_JXX) && !e_Cnd;

    // A load/use stall holds D, so a pending ret must not also bubble it.
    assign run_F_stall  = load_use | ret_pend;
    assign run_D_stall  = load_use;
    assign run_D_bubble = mispred | (ret_pend & ~load_use);
    assign run_E_bubble = mispred | load_use;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - predicted PC, fetch address select and RUN/DRAIN/HALTED pipeline control
// Optional PC_SEQ_PERF_EN adds cyc_cnt and stall_cnt performance counters.
module pc_sequencer
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  f_icode,
    input  logic [3:0]  f_ifun,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    input  logic        f_instr_valid,
    input  logic        f_imem_error,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  M_icode,
    input  logic [3:0]  W_icode,
    input  logic [3:0]  d_srcA,
    input  logic [3:0]  d_srcB,
    input  logic [3:0]  E_dstM,
    input  logic        e_Cnd,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [63:0] W_valM,
    input  logic [2:0]  W_stat,
    output logic [63:0] f_pc,
    output logic [63:0] f_predPC,
    output logic [2:0]  f_stat,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_bubble,
    output logic        W_stall,
    output logic        halted
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [63:0] cyc_cnt,
    output logic [31:0] stall_cnt
`endif
);

    seq_state_t  r_state;
    logic [63:0] r_pred_pc;

    logic w_load_use, w_ret_pend, w_mispred;
    logic w_run_F_stall, w_run_D_stall, w_run_D_bubble, w_run_E_bubble;
    logic w_unused_ifun;

    assign w_unused_ifun = ^f_ifun;

    hazard_unit u_hazard (
        .D_icode      (D_icode),
        .E_icode      (E_icode),
        .M_icode      (M_icode),
        .E_dstM       (E_dstM),
        .d_srcA       (d_srcA),
        .d_srcB       (d_srcB),
        .e_Cnd        (e_Cnd),
        .load_use     (w_load_use),
        .ret_pend     (w_ret_pend),
        .mispred      (w_mispred),
        .run_F_stall  (w_run_F_stall),
        .run_D_stall  (w_run_D_stall),
        .run_D_bubble (w_run_D_bubble),
        .run_E_bubble (w_run_E_bubble)
    );

    always_comb begin
        if (f_imem_error)        f_stat = STAT_ADR;
        else if (!f_instr_valid) f_stat = STAT_INS;
        else if (f_icode == I_HALT) f_stat = STAT_HLT;
        else                     f_stat = STAT_AOK;
    end

    always_comb begin
        if (M_icode == I_JXX && !M_Cnd) f_pc = M_valA;
        else if (W_icode == I_RET)      f_pc = W_valM;
        else                            f_pc = r_pred_pc;
    end

    assign f_predPC = r_pred_pc;

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        halted   = 1'b0;
        if (!reset) begin
            case (r_state)
                HALTED: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                    W_stall  = 1'b1;
                    halted   = 1'b1;
                end
                DRAIN: begin
                    F_stall  = 1'b1;
                    D_stall  = w_run_D_stall;
                    D_bubble = 1'b1;
                    E_bubble = w_run_E_bubble;
                end
                default: begin
                    F_stall  = w_run_F_stall;
                    D_stall  = w_run_D_stall;
                    D_bubble = w_run_D_bubble;
                    E_bubble = w_run_E_bubble;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_pred_pc <= 64'd0;
        end else begin
            if (r_state == RUN && !w_run_F_stall)
                r_pred_pc <= (f_icode == I_JXX || f_icode == I_CALL) ? f_valC : f_valP;
            // Writeback status outranks every other transition.
            if (W_stat != STAT_AOK) begin
                r_state <= HALTED;
            end else begin
                case (r_state)
                    RUN:
                        if (f_stat != STAT_AOK && !w_run_F_stall && !w_run_D_bubble)
                            r_state <= DRAIN;
                    DRAIN:
                        if (w_mispred)
                            r_state <= RUN;
                    default: r_state <= HALTED;
                endcase
            end
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [63:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc_cnt   <= 64'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (r_state != HALTED)
                r_cyc_cnt <= r_cyc_cnt + 64'd1;
            if (r_state == RUN && w_run_F_stall && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cyc_cnt   = r_cyc_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed plus randomized check of pc_sequencer against a behavioural model
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  f_icode, f_ifun;
    logic [63:0] f_valC, f_valP;
    logic        f_instr_valid, f_imem_error;
    logic [3:0]  D_icode, E_icode, M_icode, W_icode;
    logic [3:0]  d_srcA, d_srcB, E_dstM;
    logic        e_Cnd, M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [2:0]  W_stat;
    logic [63:0] f_pc, f_predPC;
    logic [2:0]  f_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
`ifdef PC_SEQ_PERF_EN
    logic [63:0] cyc_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
        .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .W_icode(W_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
        .e_Cnd(e_Cnd), .M_Cnd(M_Cnd), .M_valA(M_valA), .W_valM(W_valM), .W_stat(W_stat),
        .f_pc(f_pc), .f_predPC(f_predPC), .f_stat(f_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .halted(halted)
`ifdef PC_SEQ_PERF_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
`endif
    );

    localparam int MS_RUN = 0, MS_DRAIN = 1, MS_HALTED = 2;

    int          n_vec = 0;
    int          n_miscmp = 0;
    int          m_state;
    logic [63:0] m_pred;
    logic [63:0] m_cyc;
    logic [31:0] m_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        f_icode = 4'h1; f_ifun = 4'h0; f_valC = 64'h0; f_valP = 64'h0;
        f_instr_valid = 1'b1; f_imem_error = 1'b0;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        e_Cnd = 1'b1; M_Cnd = 1'b1; M_valA = 64'h0; W_valM = 64'h0;
        W_stat = 3'd1;
    endtask

    // Checks this cycle's outputs against the model, then advances the model across the edge.
    task automatic step();
        bit lu, rp, mp, fs, ds, db, eb, mb, ws, hl, fs_run, db_run;
        logic [63:0] pc;
        logic [2:0]  st;
        #4;
        lu = (E_icode inside {4'd5, 4'd11}) && E_dstM != 4'hF && (E_dstM == d_srcA || E_dstM == d_srcB);
        rp = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
        mp = (E_icode == 4'd7) && !e_Cnd;
        fs_run = lu || rp;
        db_run = mp || (rp && !lu);
        {fs, ds, db, eb, mb, ws, hl} = '0;
        if (!reset) begin
            if (m_state == MS_HALTED) begin
                fs = 1; ds = 1; eb = 1; mb = 1; ws = 1; hl = 1;
            end else begin
                fs = (m_state == MS_DRAIN) ? 1'b1 : fs_run;
                ds = lu;
                db = (m_state == MS_DRAIN) ? 1'b1 : db_run;
                eb = mp || lu;
            end
        end
        if (f_imem_error)        st = 3'd3;
        else if (!f_instr_valid) st = 3'd4;
        else if (f_icode == 0)   st = 3'd2;
        else                     st = 3'd1;
        if (M_icode == 4'd7 && !M_Cnd) pc = M_valA;
        else if (W_icode == 4'd9)      pc = W_valM;
        else                           pc = m_pred;

        check("f_pc", f_pc, pc);
        check("f_predPC", f_predPC, m_pred);
        check("f_stat", {61'd0, f_stat}, {61'd0, st});
        check("ctl F/D/Db/Eb/Mb/W/halt", {57'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted},
              {57'd0, fs, ds, db, eb, mb, ws, hl});
`ifdef PC_SEQ_PERF_EN
        check("cyc_cnt", cyc_cnt, m_cyc);
        check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
`endif
        @(posedge clk);
        if (reset) begin
            m_state = MS_RUN; m_pred = 64'd0; m_cyc = 64'd0; m_stall = 32'd0;
        end else begin
            if (m_state != MS_HALTED) m_cyc = m_cyc + 1;
            if (m_state == MS_RUN && fs_run && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (m_state == MS_RUN && !fs_run)
                m_pred = (f_icode inside {4'd7, 4'd8}) ? f_valC : f_valP;
            if (W_stat != 3'd1)                                    m_state = MS_HALTED;
            else if (m_state == MS_RUN && st != 3'd1 && !fs_run && !db_run) m_state = MS_DRAIN;
            else if (m_state == MS_DRAIN && mp)                    m_state = MS_RUN;
        end
        #1;
    endtask

    function automatic logic [3:0] rand_reg();
        int k = $urandom_range(0, 4);
        return (k == 4) ? 4'hF : 4'(k);
    endfunction

    initial begin
        m_state = MS_RUN; m_pred = 64'd0; m_cyc = 64'd0; m_stall = 32'd0;
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        step(); step();
        reset = 1'b0;

        f_icode = 4'h3; f_valP = 64'hA; step(); idle(); step();

        E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; step(); step(); idle();

        D_icode = 4'h9; step(); idle();
        E_icode = 4'h9; step(); idle();
        M_icode = 4'h9; step(); idle();
        W_icode = 4'h9; W_valM = 64'h40; step(); idle();

        f_icode = 4'h7; f_valC = 64'h100; step(); idle();
        E_icode = 4'h7; e_Cnd = 1'b0; step(); idle();
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h9; step(); idle();

        f_icode = 4'h0; step(); idle();
        step(); step(); step();
        W_stat = 3'd2; step(); idle();
        step(); step(); step();
        reset = 1'b1; step(); reset = 1'b0;

        f_icode = 4'h0; step(); idle();
        E_icode = 4'h7; e_Cnd = 1'b0; step(); idle();
        step(); step(); step(); step();

        f_icode = 4'h1; f_valP = 64'hFFFF_FFFF_FFFF_FFFF; step(); idle(); step();

        for (int i = 0; i < 3000; i++) begin
            f_icode = 4'($urandom_range(0, 11));
            f_ifun = 4'($urandom_range(0, 15));
            f_valC = {$urandom, $urandom};
            f_valP = {$urandom, $urandom};
            f_instr_valid = ($urandom_range(0, 15) != 0);
            f_imem_error = ($urandom_range(0, 15) == 0);
            D_icode = 4'($urandom_range(0, 11));
            E_icode = 4'($urandom_range(0, 11));
            M_icode = 4'($urandom_range(0, 11));
            W_icode = 4'($urandom_range(0, 11));
            d_srcA = rand_reg(); d_srcB = rand_reg(); E_dstM = rand_reg();
            e_Cnd = $urandom_range(0, 1) != 0;
            M_Cnd = $urandom_range(0, 1) != 0;
            M_valA = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            W_stat = ($urandom_range(0, 63) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            reset = ($urandom_range(0, 99) == 0) || (m_state == MS_HALTED && $urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
